// File: rtl/wr_burst_pkg.sv
// rtl/wr_burst_pkg.sv - shared state encoding and width helpers for the write burst arbiter
package wr_burst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        STREAM,
        DRAIN,
        WAIT_REL,
        FLUSH
    } state_t;

    // A single-channel build still carries a 1-bit grant id so vectors never collapse to zero width.
    function automatic int grant_id_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int burst_cnt_width(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/wr_skid_buf.sv
// rtl/wr_skid_buf.sv - two-entry single-clock skid buffer between granted source and write FIFO
module wr_skid_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         empty,
    output logic         full,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);
    assign head  = mem[rd_ptr_q];

    // Callers only push when not full and only pop when not empty.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/wr_burst_arbiter.sv
// rtl/wr_burst_arbiter.sv - round-robin multi-channel write burst front end; WR_BURST_TIMEOUT_EN adds a REQ timeout
module wr_burst_arbiter
    import wr_burst_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_CH         = 4,
    parameter int CFG_WIDTH      = 4,
    parameter int BURST_LEN      = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                         clk_chip,
    input  logic                                         reset_chip,
    input  logic [NUM_CH-1:0]                            ch_start,
    input  logic [NUM_CH*CFG_WIDTH-1:0]                  ch_cfg,
    output logic [NUM_CH-1:0]                            config_ready,
    input  logic [NUM_CH-1:0]                            ch_req,
    input  logic [NUM_CH*DATA_WIDTH-1:0]                 ch_data,
    output logic [NUM_CH-1:0]                            ch_ready,
    output logic                                         config_req,
    output logic [grant_id_width(NUM_CH)+CFG_WIDTH-1:0]  config_word,
    input  logic                                         link_active,
    output logic                                         fifo_wr_en,
    output logic [DATA_WIDTH-1:0]                        fifo_din,
    input  logic                                         fifo_full,
    output logic                                         fifo_flush,
    output logic                                         burst_abort,
    output logic                                         busy
);

    localparam int ID_W  = grant_id_width(NUM_CH);
    localparam int CNT_W = burst_cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN);

    state_t                state_q, state_d;
    logic [NUM_CH-1:0]     pending_q, clr_mask;
    logic [ID_W-1:0]       rr_ptr_q, grant_q, grant_d;
    logic [CFG_WIDTH-1:0]  tag_q;
    logic [CNT_W-1:0]      in_cnt_q, out_cnt_q;
    logic                  abort_q, abort_d, any_pending;
    logic                  can_accept, push, pop, skid_empty, skid_full;
    logic [DATA_WIDTH-1:0] skid_head;
    logic [CFG_WIDTH-1:0]  cfg_arr  [NUM_CH];
    logic [DATA_WIDTH-1:0] data_arr [NUM_CH];
    int                    idx;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            cfg_arr[k]  = ch_cfg[k*CFG_WIDTH +: CFG_WIDTH];
            data_arr[k] = ch_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First pending channel at or after rr_ptr, wrapping.
    always_comb begin
        grant_d     = rr_ptr_q;
        any_pending = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_CH;
            if (!any_pending && pending_q[ID_W'(idx)]) begin
                any_pending = 1'b1;
                grant_d     = ID_W'(idx);
            end
        end
    end

`ifdef WR_BURST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    always_ff @(posedge clk_chip) begin
        if (reset_chip || state_q != REQ) tmo_cnt_q <= '0;
        else if (tmo_cnt_q != TMO_LAST)   tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d = state_q;
        abort_d = 1'b0;
        unique case (state_q)
            IDLE: if (any_pending) state_d = REQ;
            REQ: begin
                if (link_active) state_d = STREAM;
`ifdef WR_BURST_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = FLUSH;
                    abort_d = 1'b1;
                end
`endif
            end
            STREAM: begin
                if (!link_active) begin
                    state_d = FLUSH;
                    abort_d = 1'b1;
                end else if (in_cnt_q == LAST) state_d = DRAIN;
            end
            DRAIN: begin
                if (!link_active) begin
                    state_d = FLUSH;
                    abort_d = 1'b1;
                end else if (skid_empty && out_cnt_q == LAST) state_d = WAIT_REL;
            end
            WAIT_REL: if (!link_active) state_d = FLUSH;
            FLUSH:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign can_accept = (state_q == STREAM) && !skid_full && (in_cnt_q != LAST);
    assign push       = can_accept && ch_req[grant_q];
    // No writes in FLUSH: an aborted burst's leftovers must not reach the cleared FIFO.
    assign pop        = !skid_empty && !fifo_full && (state_q != FLUSH);

    always_comb begin
        ch_ready = '0;
        if (can_accept) ch_ready[grant_q] = 1'b1;
        clr_mask = '0;
        if (state_q == FLUSH) clr_mask[grant_q] = 1'b1;
    end

    always_ff @(posedge clk_chip) begin
        if (reset_chip) begin
            state_q   <= IDLE;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            tag_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            abort_q   <= abort_d;
            pending_q <= (pending_q | ch_start) & ~clr_mask;
            if (state_q == IDLE && any_pending) begin
                grant_q <= grant_d;
                tag_q   <= cfg_arr[grant_d];
            end
            if (state_q == FLUSH) begin
                rr_ptr_q  <= (grant_q == ID_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                if (push) in_cnt_q <= in_cnt_q + 1'b1;
                if (pop && out_cnt_q != LAST) out_cnt_q <= out_cnt_q + 1'b1;
            end
        end
    end

    wr_skid_buf #(.W(DATA_WIDTH)) u_skid (
        .clk       (clk_chip),
        .reset     (reset_chip),
        .flush     (state_q == FLUSH),
        .push      (push),
        .push_data (data_arr[grant_q]),
        .pop       (pop),
        .empty     (skid_empty),
        .full      (skid_full),
        .head      (skid_head)
    );

    assign config_ready = ~pending_q;
    assign config_req   = (state_q == REQ);
    assign busy         = (state_q != IDLE);
    assign config_word  = busy ? {grant_q, tag_q} : '0;
    assign fifo_wr_en   = pop;
    assign fifo_din     = skid_empty ? '0 : skid_head;
    assign fifo_flush   = (state_q == FLUSH);
    assign burst_abort  = abort_q;

endmodule

// File: tb/tb_wr_burst_arbiter.sv
// tb/tb_wr_burst_arbiter.sv - directed self-checking bench for wr_burst_arbiter
module tb_wr_burst_arbiter;

    localparam int DW  = 32;
    localparam int NCH = 4;
    localparam int CW  = 4;
    localparam int BL  = 64;

    logic              clk_chip = 1'b0;
    logic              reset_chip = 1'b1;
    logic [NCH-1:0]    ch_start = '0;
    logic [NCH*CW-1:0] ch_cfg = 16'hDCBA;
    logic [NCH-1:0]    config_ready;
    logic [NCH-1:0]    ch_req = '0;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_ready;
    logic              config_req;
    logic [5:0]        config_word;
    logic              link_active = 1'b0;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_din;
    logic              fifo_full = 1'b0;
    logic              fifo_flush;
    logic              burst_abort;
    logic              busy;

    int          n_vec = 0;
    int          n_err = 0;
    int          wr_count = 0;
    int          flush_count = 0;
    int          abort_count = 0;
    int unsigned sent [NCH];
    logic [31:0] sb_q [$];
    bit          toggle_en = 1'b0;
    int          phase = 0;

    logic [NCH-1:0] mon_hs;
    logic           mon_wr, mon_fl, mon_ab, mon_rs;
    logic [DW-1:0]  mon_din;

    wr_burst_arbiter #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .CFG_WIDTH(CW), .BURST_LEN(BL), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_chip     (clk_chip),
        .reset_chip   (reset_chip),
        .ch_start     (ch_start),
        .ch_cfg       (ch_cfg),
        .config_ready (config_ready),
        .ch_req       (ch_req),
        .ch_data      (ch_data),
        .ch_ready     (ch_ready),
        .config_req   (config_req),
        .config_word  (config_word),
        .link_active  (link_active),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_din     (fifo_din),
        .fifo_full    (fifo_full),
        .fifo_flush   (fifo_flush),
        .burst_abort  (burst_abort),
        .busy         (busy)
    );

    always #5 clk_chip = ~clk_chip;

    always_comb begin
        for (int k = 0; k < NCH; k++) ch_data[k*DW +: DW] = {8'(k), 24'(sent[k])};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_chip);
        #2;
    endtask

    // Scoreboard: every accepted source word must leave through fifo_din once, in order.
    always begin
        @(negedge clk_chip);
        mon_hs  = ch_req & ch_ready;
        mon_wr  = fifo_wr_en;
        mon_din = fifo_din;
        mon_fl  = fifo_flush;
        mon_ab  = burst_abort;
        mon_rs  = reset_chip;
        check_eq("wr_en_model", 32'(fifo_wr_en), 32'(sb_q.size() != 0 && !fifo_full && !fifo_flush));
        if (sb_q.size() == 0) check_eq("din_idle", fifo_din, 32'd0);
        if (sb_q.size() >= 2) check_eq("ready_at_skid_full", 32'(ch_ready), 32'd0);
        if (sb_q.size() > 2)  check_eq("skid_depth", 32'(sb_q.size()), 32'd2);
        @(posedge clk_chip);
        #1;
        if (mon_wr) begin
            wr_count++;
            if (sb_q.size() != 0) check_eq("fifo_din", mon_din, sb_q.pop_front());
        end
        for (int i = 0; i < NCH; i++) begin
            if (mon_hs[i]) begin
                sb_q.push_back({8'(i), 24'(sent[i])});
                sent[i]++;
            end
        end
        if (mon_fl) flush_count++;
        if (mon_ab) abort_count++;
        if (mon_fl || mon_rs) sb_q.delete();
        if (toggle_en) begin
            fifo_full = (phase < 3);
            phase     = (phase + 1) % 5;
        end else begin
            fifo_full = 1'b0;
            phase     = 0;
        end
    end

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_config_req"},   32'(config_req),   32'd0);
        check_eq({tag, "_ch_ready"},     32'(ch_ready),     32'd0);
        check_eq({tag, "_config_ready"}, 32'(config_ready), 32'hF);
        check_eq({tag, "_fifo_wr_en"},   32'(fifo_wr_en),   32'd0);
        check_eq({tag, "_fifo_din"},     fifo_din,          32'd0);
        check_eq({tag, "_fifo_flush"},   32'(fifo_flush),   32'd0);
        check_eq({tag, "_burst_abort"},  32'(burst_abort),  32'd0);
        check_eq({tag, "_busy"},         32'(busy),         32'd0);
        check_eq({tag, "_config_word"},  32'(config_word),  32'd0);
    endtask

    task automatic reset_dut();
        reset_chip = 1'b1;
        link_active = 1'b0;
        repeat (2) tick();
        check_reset_vals("reset");
        reset_chip = 1'b0;
    endtask

    task automatic pulse_start(input logic [NCH-1:0] m);
        ch_start = m;
        tick();
        ch_start = '0;
    endtask

    task automatic wait_flush(input string tag);
        int t;
        t = 0;
        while (!fifo_flush && t < 10) begin
            tick();
            t++;
        end
        check_eq({tag, "_flush_seen"}, 32'(fifo_flush), 32'd1);
    endtask

    // Serve one burst on channel ch; abort_after > 0 drops the link after that many writes.
    task automatic serve(input int ch, input int link_delay, input int abort_after);
        int t, w0, a0, f0;
        t = 0;
        while (!config_req && t < 30) begin
            tick();
            t++;
        end
        check_eq("req_seen", 32'(config_req), 32'd1);
        check_eq("grant_id", 32'(config_word[5:4]), 32'(ch));
        check_eq("grant_tag", 32'(config_word[3:0]), 32'(10 + ch));
        w0 = wr_count;
        a0 = abort_count;
        f0 = flush_count;
        repeat (link_delay) tick();
        link_active = 1'b1;
        tick();
        check_eq("stream_req_low", 32'(config_req), 32'd0);
        check_eq("stream_ready", 32'(ch_ready), 32'(1 << ch));
        t = 0;
        if (abort_after > 0) begin
            while (wr_count - w0 < abort_after && t < 500) begin
                tick();
                t++;
            end
            link_active = 1'b0;
            wait_flush("abort");
            check_eq("abort_pulse", 32'(burst_abort), 32'd1);
            tick();
            check_eq("abort_idle", 32'(busy), 32'd0);
            check_eq("abort_pulse_end", 32'(burst_abort), 32'd0);
            check_eq("abort_count", 32'(abort_count - a0), 32'd1);
            check_eq("abort_flush_count", 32'(flush_count - f0), 32'd1);
            check_eq("abort_ready_back", 32'(config_ready[ch]), 32'd1);
        end else begin
            while (wr_count - w0 < BL && t < 1000) begin
                tick();
                t++;
            end
            repeat (3) tick();
            check_eq("burst_words", 32'(wr_count - w0), 32'(BL));
            check_eq("drain_ready_low", 32'(ch_ready), 32'd0);
            check_eq("wait_rel_busy", 32'(busy), 32'd1);
            link_active = 1'b0;
            wait_flush("burst");
            check_eq("burst_no_abort", 32'(burst_abort), 32'd0);
            tick();
            check_eq("burst_flush_count", 32'(flush_count - f0), 32'd1);
            check_eq("burst_abort_count", 32'(abort_count - a0), 32'd0);
            check_eq("burst_ready_back", 32'(config_ready[ch]), 32'd1);
            check_eq("burst_sb_empty", 32'(sb_q.size()), 32'd0);
        end
    endtask

    initial begin
        int t, n, w0;
        ch_req = '1;

        // Single burst on ch2 with the exact start-up timing
        reset_dut();
        ch_start = 4'b0100;
        tick();
        ch_start = '0;
        check_eq("pending_set", 32'(config_ready), 32'hB);
        check_eq("idle_after_start", 32'(busy), 32'd0);
        tick();
        check_eq("req_after_edge2", 32'(config_req), 32'd1);
        check_eq("config_word_ch2", 32'(config_word), 32'h2C);
        serve(2, 4, 0);

        // Round robin from reset: 0, 1, 3, then ch0 again
        reset_dut();
        pulse_start(4'b1011);
        serve(0, 2, 0);
        pulse_start(4'b0001);
        serve(1, 1, 0);
        serve(3, 1, 0);
        serve(0, 1, 0);

        // Backpressure: fifo_full 3 on / 2 off
        toggle_en = 1'b1;
        pulse_start(4'b0010);
        serve(1, 3, 0);
        toggle_en = 1'b0;
        tick();

        // Abort after 10 words, then a clean burst
        pulse_start(4'b0010);
        serve(1, 1, 10);
        pulse_start(4'b0100);
        serve(2, 2, 0);

`ifdef WR_BURST_TIMEOUT_EN
        pulse_start(4'b1000);
        t = 0;
        while (!config_req && t < 30) begin
            tick();
            t++;
        end
        n = 0;
        while (config_req && n < 100) begin
            n++;
            tick();
        end
        check_eq("timeout_req_cycles", 32'(n), 32'd16);
        check_eq("timeout_abort", 32'(burst_abort), 32'd1);
        check_eq("timeout_flush", 32'(fifo_flush), 32'd1);
        check_eq("timeout_req_low", 32'(config_req), 32'd0);
        tick();
        check_eq("timeout_idle", 32'(busy), 32'd0);
`endif

        // Reset in the middle of a stream
        pulse_start(4'b0001);
        t = 0;
        while (!config_req && t < 30) begin
            tick();
            t++;
        end
        w0 = wr_count;
        link_active = 1'b1;
        t = 0;
        while (wr_count - w0 < 5 && t < 100) begin
            tick();
            t++;
        end
        check_eq("midstream_busy", 32'(busy), 32'd1);
        reset_chip = 1'b1;
        tick();
        check_reset_vals("midreset");
        reset_chip = 1'b0;
        link_active = 1'b0;
        repeat (2) tick();
        check_eq("midreset_no_pending", 32'(busy), 32'd0);
        check_eq("midreset_ready", 32'(config_ready), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
